// File: rtl/pulse_dec_pkg.sv
// Shared types and default constants for the pulse width decoder.
//   dec_state_t   : decoder FSM states
//   DEC_NOM_WIDTH : default nominal pulse width in clock cycles
//   DEC_TOL       : default accepted deviation in clock cycles
package pulse_dec_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEASURE  = 2'd2
  } dec_state_t;

  localparam int DEC_NOM_WIDTH = 32;
  localparam int DEC_TOL       = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Used by pulse_width_decoder only when PULSE_WIDTH_DECODER_SYNC_EN is defined.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input level
//   q   : level synchronized to clk (2-cycle delay)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of d into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pulse_width_decoder.sv
// Pulse width decoder: measures the high time of a stretched level pulse and
// turns it back into a single-cycle strobe.
//   evt fires once when a pulse of NOM_WIDTH-TOL .. NOM_WIDTH+TOL cycles ends.
//   err fires once when a pulse ends too short, or as soon as it grows past
//   NOM_WIDTH+TOL cycles (the rest of that overlong pulse is then ignored).
// Optional macro: PULSE_WIDTH_DECODER_SYNC_EN inserts a 2-flop synchronizer
// on pulse_in (all latencies +2 cycles). Without it pulse_in must already be
// synchronous to clk.
// Ports:
//   clk      : sole clock, rising edge
//   rst      : synchronous active-high reset
//   pulse_in : stretched pulse from the transmitter
//   evt      : one-cycle strobe, valid-width pulse ended
//   err      : one-cycle strobe, pulse too short or too long
//   width    : last measured high time, saturating at NOM_WIDTH+TOL+1
//   busy     : high while a pulse is being measured
module pulse_width_decoder
  import pulse_dec_pkg::*;
#(
  parameter  int NOM_WIDTH = DEC_NOM_WIDTH,
  parameter  int TOL       = DEC_TOL,
  localparam int CNT_W     = $clog2(NOM_WIDTH + TOL + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             evt,
  output logic             err,
  output logic [CNT_W-1:0] width,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(NOM_WIDTH - TOL);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NOM_WIDTH + TOL);
  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(NOM_WIDTH + TOL + 1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic             p_s;
  dec_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] width_r, width_nxt_s;
  logic             evt_r, evt_nxt_s;
  logic             err_r, err_nxt_s;
  logic             busy_r, busy_nxt_s;

`ifdef PULSE_WIDTH_DECODER_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pulse_in),
    .q   (p_s)
  );
`else
  assign p_s = pulse_in;
`endif

  // Next-state, counter and strobe decisions
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    width_nxt_s = width_r;
    evt_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      // A pulse already high when we come out of reset (or an overlong one)
      // is ignored until the line has been seen low.
      WAIT_LOW: begin
        if (!p_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_LOW;
        end
      end
      IDLE: begin
        if (p_s) begin
          state_nxt_s = MEASURE;
          cnt_nxt_s   = ONE_CNT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEASURE: begin
        if (p_s) begin
          if (cnt_r >= MAX_CNT) begin
            // Overlong: report once, then wait for the line to drop.
            cnt_nxt_s   = SAT_CNT;
            width_nxt_s = SAT_CNT;
            err_nxt_s   = 1'b1;
            state_nxt_s = WAIT_LOW;
          end else begin
            cnt_nxt_s   = cnt_r + ONE_CNT;
          end
        end else begin
          // Falling edge: cnt can never exceed MAX_CNT here, so anything
          // not short is in range.
          width_nxt_s = cnt_r;
          state_nxt_s = IDLE;
          if (cnt_r < MIN_CNT) begin
            err_nxt_s = 1'b1;
          end else begin
            evt_nxt_s = 1'b1;
          end
        end
      end
      default: begin
        state_nxt_s = WAIT_LOW;
      end
    endcase
    busy_nxt_s = (state_nxt_s == MEASURE);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_LOW;
      cnt_r   <= '0;
      width_r <= '0;
      evt_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      width_r <= width_nxt_s;
      evt_r   <= evt_nxt_s;
      err_r   <= err_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign evt   = evt_r;
  assign err   = err_r;
  assign width = width_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Self-checking bench for pulse_width_decoder: a run-length model of the
// sampled line predicts evt/err/width/busy every cycle, and directed pulses
// check counts, widths and strobe timing against hand-computed values.
module tb_pulse_width_decoder;

  localparam int NOM   = 32;
  localparam int TOL   = 2;
  localparam int CW    = $clog2(NOM + TOL + 2);
`ifdef PULSE_WIDTH_DECODER_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse_in = 1'b0;
  logic          evt, err, busy;
  logic [CW-1:0] width;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pulse_width_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .evt      (evt),
    .err      (err),
    .width    (width),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: run length of the sampled line ----------------
  bit [1:0] sh;
  bit       prev_p, have_prev, run_ok, started;
  int       run_len;
  int       exp_evt, exp_err, exp_width, exp_busy;

  always @(posedge clk) begin
    bit p;
    if (rst) begin
      sh = 2'b00; have_prev = 0; run_ok = 0; run_len = 0; prev_p = 0;
      exp_evt = 0; exp_err = 0; exp_width = 0; exp_busy = 0;
    end else begin
      if (EXTRA != 0) begin
        p  = sh[1];
        sh = {sh[0], pulse_in};
      end else begin
        p = pulse_in;
      end
      exp_evt = 0;
      exp_err = 0;
      if (p) begin
        if (!have_prev || !prev_p) begin
          run_ok  = have_prev;   // run counts only if a low was seen first
          run_len = 1;
        end else if (run_len < 1000) begin
          run_len++;
        end
        if (run_ok && run_len == NOM + TOL + 1) begin
          exp_err = 1; exp_width = NOM + TOL + 1;
        end
        exp_busy = (run_ok && run_len <= NOM + TOL) ? 1 : 0;
      end else begin
        if (have_prev && prev_p && run_ok && run_len <= NOM + TOL) begin
          exp_width = run_len;
          if (run_len >= NOM - TOL) exp_evt = 1; else exp_err = 1;
        end
        exp_busy = 0;
        run_len  = 0;
      end
      prev_p = p;
      have_prev = 1;
    end
    started = 1;
  end

  // ---------------- per-cycle compare and strobe monitor -----------------
  int n_evt = 0, n_err = 0, last_evt_cyc = -1, prev_evt_cyc = -1;
  int last_err_cyc = -1, strobe_width = -1;

  always @(negedge clk) begin
    if (started) begin
      chk("evt_model",   int'(evt),   exp_evt);
      chk("err_model",   int'(err),   exp_err);
      chk("width_model", int'(width), exp_width);
      chk("busy_model",  int'(busy),  exp_busy);
      checks++;
      if (evt && err) begin
        failures++;
        $display("FAIL evt_err_excl: got both high expected exclusive (cycle %0d)", cyc);
      end
    end
    if (evt) begin
      n_evt++; prev_evt_cyc = last_evt_cyc; last_evt_cyc = cyc; strobe_width = int'(width);
    end
    if (err) begin
      n_err++; last_err_cyc = cyc; strobe_width = int'(width);
    end
  end

  task automatic run_pulse(input int hi, input int lo, output int rise, output int fall);
    rise = 0;
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      pulse_in = 1'b1;
      if (i == 0) rise = cyc + 1;
    end
    @(negedge clk);
    pulse_in = 1'b0;
    fall = cyc + 1;
    for (int i = 0; i < lo - 1; i++) @(negedge clk);
  endtask

  int r, f, e0, x0;

  initial begin
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_evt", int'(evt), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_width", int'(width), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // nominal 32-cycle pulse
    e0 = n_evt; x0 = n_err;
    run_pulse(32, 10, r, f);
    chk("p32_evt_cnt", n_evt - e0, 1);
    chk("p32_err_cnt", n_err - x0, 0);
    chk("p32_width", strobe_width, 32);
    chk("p32_latency", last_evt_cyc - f, EXTRA);

    // short 29 -> err
    e0 = n_evt; x0 = n_err;
    run_pulse(29, 10, r, f);
    chk("p29_evt_cnt", n_evt - e0, 0);
    chk("p29_err_cnt", n_err - x0, 1);
    chk("p29_width", strobe_width, 29);
    chk("p29_latency", last_err_cyc - f, EXTRA);

    // lower bound 30 -> evt
    e0 = n_evt; x0 = n_err;
    run_pulse(30, 10, r, f);
    chk("p30_evt_cnt", n_evt - e0, 1);
    chk("p30_err_cnt", n_err - x0, 0);
    chk("p30_width", strobe_width, 30);

    // upper bound 34 -> evt
    e0 = n_evt; x0 = n_err;
    run_pulse(34, 10, r, f);
    chk("p34_evt_cnt", n_evt - e0, 1);
    chk("p34_width", strobe_width, 34);

    // overlong 40 -> single err after 35th high sample, nothing at the fall
    e0 = n_evt; x0 = n_err;
    run_pulse(40, 10, r, f);
    chk("p40_evt_cnt", n_evt - e0, 0);
    chk("p40_err_cnt", n_err - x0, 1);
    chk("p40_width", strobe_width, 35);
    chk("p40_err_time", last_err_cyc - r, 34 + EXTRA);

    e0 = n_evt; x0 = n_err;
    run_pulse(32, 10, r, f);
    chk("after_long_evt_cnt", n_evt - e0, 1);
    chk("after_long_width", strobe_width, 32);

    // back-to-back with a single low sample
    e0 = n_evt; x0 = n_err;
    run_pulse(32, 1, r, f);
    run_pulse(32, 10, r, f);
    chk("b2b_evt_cnt", n_evt - e0, 2);
    chk("b2b_err_cnt", n_err - x0, 0);
    chk("b2b_spacing", last_evt_cyc - prev_evt_cyc, 33);
    chk("b2b_width", strobe_width, 32);

    // reset in the middle of a pulse that stays high afterwards
    e0 = n_evt; x0 = n_err;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      pulse_in = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_evt", int'(evt), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_width", int'(width), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (18) @(negedge clk);
    pulse_in = 1'b0;
    repeat (10) @(negedge clk);
`ifndef PULSE_WIDTH_DECODER_SYNC_EN
    chk("midrst_evt_cnt", n_evt - e0, 0);
    chk("midrst_err_cnt", n_err - x0, 0);
`endif
    e0 = n_evt; x0 = n_err;
    run_pulse(32, 10, r, f);
    chk("after_rst_evt_cnt", n_evt - e0, 1);
    chk("after_rst_width", strobe_width, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
